// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the core's fetch/data ports, the arbiter and the
// external memory bus. The arbiter connects through the slave modport; the
// core/memory environment drives the master side.
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Fetch side
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;

    // Data side
    logic          d_req;
    logic          d_write;
    logic [1:0]    d_size;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    // External memory bus
    logic          mem_req;
    logic          mem_write;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack_n;

    // Error reporting
    logic          bus_err;
    logic          err_src;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_write, d_size, d_addr, d_wdata,
        input  mem_rdata, mem_ack_n,
        output i_ack, i_rdata, d_ack, d_rdata,
        output mem_req, mem_write, mem_size, mem_addr, mem_wdata,
        output bus_err, err_src
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_write, d_size, d_addr, d_wdata,
        output mem_rdata, mem_ack_n,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  mem_req, mem_write, mem_size, mem_addr, mem_wdata,
        input  bus_err, err_src
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// data access. One transaction at a time; misaligned data accesses are
// rejected without a bus cycle, and a stuck bus is aborted after TIMEOUT
// busy cycles. All outputs are registered.
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255   // 1..255
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DERR} state_t;

    // Busy cycles are counted from 0, so the abort fires on the edge that
    // ends the TIMEOUT-th busy cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last_data;   // 1 when the data side won the previous grant
    logic [7:0] tmo_cnt;

    logic       pick_data;
    logic       grant_i;
    logic       grant_d;
    logic       misaligned;
    logic       acked;
    logic       timed_out;

    // Arbitration, alignment check and next-state decode.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case leaves it unassigned (which would infer a latch).
        state_nxt  = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        misaligned = 1'b0;
        acked      = 1'b0;
        timed_out  = 1'b0;
        pick_data  = bus.d_req && (!bus.i_req || !last_data);

        unique case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    if (pick_data) begin
                        grant_d    = 1'b1;
                        misaligned = ((bus.d_size == 2'b00) && (bus.d_addr[1:0] != 2'b00)) ||
                                     ((bus.d_size == 2'b01) && bus.d_addr[0]);
                        state_nxt  = misaligned ? DERR : DBUSY;
                    end else begin
                        grant_i   = 1'b1;
                        state_nxt = IBUSY;
                    end
                end
            end
            IBUSY, DBUSY: begin
                acked     = !bus.mem_ack_n;
                timed_out = bus.mem_ack_n && (tmo_cnt == TMO_LAST);
                if (acked || timed_out) begin
                    state_nxt = IDLE;
                end
            end
            DERR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus fields, completion pulses, read data, timeout counter and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the bus fields and read-data holding registers are reset
            // too, not only the control state, because every output must
            // read 0 after reset.
            last_data     <= 1'b1;
            tmo_cnt       <= 8'd0;
            bus.i_ack     <= 1'b0;
            bus.i_rdata   <= {DW{1'b0}};
            bus.d_ack     <= 1'b0;
            bus.d_rdata   <= {DW{1'b0}};
            bus.mem_req   <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_size  <= 2'b00;
            bus.mem_addr  <= {AW{1'b0}};
            bus.mem_wdata <= {DW{1'b0}};
            bus.bus_err   <= 1'b0;
            bus.err_src   <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle.
            bus.i_ack <= 1'b0;
            bus.d_ack <= 1'b0;

            if (grant_i) begin
                last_data     <= 1'b0;
                tmo_cnt       <= 8'd0;
                bus.mem_req   <= 1'b1;
                bus.mem_write <= 1'b0;
                bus.mem_size  <= 2'b00;
                bus.mem_addr  <= bus.i_addr;
            end

            if (grant_d) begin
                last_data <= 1'b1;
                if (misaligned) begin
                    // Rejected locally: answer immediately, bus untouched.
                    bus.d_ack   <= 1'b1;
                    bus.d_rdata <= {DW{1'b0}};
                    bus.bus_err <= 1'b1;
                    bus.err_src <= 1'b1;
                end else begin
                    tmo_cnt       <= 8'd0;
                    bus.mem_req   <= 1'b1;
                    bus.mem_write <= bus.d_write;
                    bus.mem_size  <= (bus.d_size == 2'b11) ? 2'b10 : bus.d_size;
                    bus.mem_addr  <= bus.d_addr;
                    bus.mem_wdata <= bus.d_wdata;
                end
            end

            if (acked || timed_out) begin
                // An ack on the same edge as the timeout wins.
                bus.mem_req <= 1'b0;
                if (state == IBUSY) begin
                    bus.i_ack   <= 1'b1;
                    bus.i_rdata <= acked ? bus.mem_rdata : {DW{1'b0}};
                end else begin
                    bus.d_ack   <= 1'b1;
                    bus.d_rdata <= acked ? bus.mem_rdata : {DW{1'b0}};
                end
                if (timed_out) begin
                    bus.bus_err <= 1'b1;
                    bus.err_src <= (state == DBUSY);
                end
            end else if (state == IBUSY || state == DBUSY) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized requesters and memory, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_mem_bus_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          i_ack;
        logic [DW-1:0] i_rdata;
        logic          d_ack;
        logic [DW-1:0] d_rdata;
        logic          mem_req;
        logic          mem_write;
        logic [1:0]    mem_size;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata;
        logic          bus_err;
        logic          err_src;
    } outs_t;

    outs_t e;               // expected outputs for the cycle after the edge
    bit    on_bus;          // a transaction occupies the memory bus
    bit    owner_data;      // side owning the bus transaction
    int    age;             // busy cycles elapsed for the current transaction
    bit    reject_cycle;    // one-cycle misalignment answer in progress
    bit    last_was_data;   // round-robin memory

    function automatic int unsigned access_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    endfunction

    task automatic finish_txn(input logic [DW-1:0] data, input bit aborted);
        on_bus    = 1'b0;
        e.mem_req = 1'b0;
        if (owner_data) begin
            e.d_ack   = 1'b1;
            e.d_rdata = data;
        end else begin
            e.i_ack   = 1'b1;
            e.i_rdata = data;
        end
        if (aborted) begin
            e.bus_err = 1'b1;
            e.err_src = owner_data;
        end
    endtask

    task automatic model_step();
        bit take_data;
        if (rst) begin
            e             = '0;
            on_bus        = 1'b0;
            reject_cycle  = 1'b0;
            last_was_data = 1'b1;
            age           = 0;
            return;
        end
        e.i_ack = 1'b0;
        e.d_ack = 1'b0;
        if (on_bus) begin
            age++;
            if (bus.mem_ack_n == 1'b0)
                finish_txn(bus.mem_rdata, 1'b0);
            else if (age == TMO)
                finish_txn('0, 1'b1);
        end else if (reject_cycle) begin
            reject_cycle = 1'b0;
        end else if (bus.i_req || bus.d_req) begin
            take_data     = bus.d_req && !(bus.i_req && last_was_data);
            last_was_data = take_data;
            if (take_data && (int'(bus.d_addr[1:0]) % access_bytes(bus.d_size)) != 0) begin
                reject_cycle = 1'b1;
                e.d_ack      = 1'b1;
                e.d_rdata    = '0;
                e.bus_err    = 1'b1;
                e.err_src    = 1'b1;
            end else begin
                on_bus     = 1'b1;
                owner_data = take_data;
                age        = 0;
                e.mem_req  = 1'b1;
                if (take_data) begin
                    e.mem_write = bus.d_write;
                    e.mem_size  = (access_bytes(bus.d_size) == 4) ? 2'b00 :
                                  (access_bytes(bus.d_size) == 2) ? 2'b01 : 2'b10;
                    e.mem_addr  = bus.d_addr;
                    e.mem_wdata = bus.d_wdata;
                end else begin
                    e.mem_write = 1'b0;
                    e.mem_size  = 2'b00;
                    e.mem_addr  = bus.i_addr;
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    // Compare DUT outputs with the model every cycle, away from the clock edge.
    always @(negedge clk) begin
        check("cyc_i_ack",   bus.i_ack,   e.i_ack);
        check("cyc_d_ack",   bus.d_ack,   e.d_ack);
        check("cyc_i_rdata", bus.i_rdata, e.i_rdata);
        check("cyc_d_rdata", bus.d_rdata, e.d_rdata);
        check("cyc_mem_req", bus.mem_req, e.mem_req);
        check("cyc_bus_err", bus.bus_err, e.bus_err);
        check("cyc_err_src", bus.err_src, e.err_src);
        if (e.mem_req) begin
            check("cyc_mem_addr",  bus.mem_addr,  e.mem_addr);
            check("cyc_mem_size",  bus.mem_size,  e.mem_size);
            check("cyc_mem_write", bus.mem_write, e.mem_write);
            if (e.mem_write) check("cyc_mem_wdata", bus.mem_wdata, e.mem_wdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_size    = 2'b00;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack_n = 1'b1;
        rst           = 1'b1;
        @(negedge clk);
        tick();

        // Reset state: every output 0.
        check("rst_mem_req",   bus.mem_req,   1'b0);
        check("rst_mem_addr",  bus.mem_addr,  32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_mem_size",  bus.mem_size,  2'b00);
        check("rst_i_ack",     bus.i_ack,     1'b0);
        check("rst_d_ack",     bus.d_ack,     1'b0);
        check("rst_bus_err",   bus.bus_err,   1'b0);

        // Zero-wait fetch.
        rst           = 1'b0;
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h0000_0010;
        bus.mem_ack_n = 1'b0;
        bus.mem_rdata = 32'h00A0_0093;
        tick();
        check("f1_mem_req",  bus.mem_req,  1'b1);
        check("f1_mem_addr", bus.mem_addr, 32'h10);
        check("f1_mem_size", bus.mem_size, 2'b00);
        check("f1_i_ack_early", bus.i_ack, 1'b0);
        tick();
        check("f1_i_ack",   bus.i_ack,   1'b1);
        check("f1_i_rdata", bus.i_rdata, 32'h00A0_0093);
        check("f1_mem_req_low", bus.mem_req, 1'b0);
        bus.i_req     = 1'b0;
        bus.mem_ack_n = 1'b1;
        tick();
        check("f1_i_ack_once", bus.i_ack, 1'b0);

        // Fetch timeout: mem_req for TMO cycles, then ack with zero data.
        check("to_err_before", bus.bus_err, 1'b0);
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h0000_0040;
        bus.mem_rdata = 32'h5555_5555;
        for (int k = 0; k < TMO; k++) begin
            tick();
            check("to_mem_req", bus.mem_req, 1'b1);
            check("to_no_ack",  bus.i_ack,   1'b0);
        end
        tick();
        check("to_mem_req_low", bus.mem_req, 1'b0);
        check("to_i_ack",       bus.i_ack,   1'b1);
        check("to_i_rdata",     bus.i_rdata, 32'h0);
        check("to_bus_err",     bus.bus_err, 1'b1);
        check("to_err_src",     bus.err_src, 1'b0);
        bus.i_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("to_err_sticky", bus.bus_err, 1'b1);
        end

        // Misaligned word load: no bus cycle, immediate error answer.
        bus.d_req   = 1'b1;
        bus.d_write = 1'b0;
        bus.d_size  = 2'b00;
        bus.d_addr  = 32'h0800_0002;
        tick();
        check("mis_mem_req", bus.mem_req, 1'b0);
        check("mis_d_ack",   bus.d_ack,   1'b1);
        check("mis_d_rdata", bus.d_rdata, 32'h0);
        check("mis_bus_err", bus.bus_err, 1'b1);
        check("mis_err_src", bus.err_src, 1'b1);
        bus.d_req = 1'b0;
        tick();
        check("mis_d_ack_once", bus.d_ack, 1'b0);

        // Reset clears the sticky error.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_bus_err", bus.bus_err, 1'b0);
        check("rst2_err_src", bus.err_src, 1'b0);

        // Both sides held: fetch first, then strict alternation.
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h0000_0020;
        bus.d_req     = 1'b1;
        bus.d_write   = 1'b0;
        bus.d_size    = 2'b00;
        bus.d_addr    = 32'h0800_0004;
        bus.mem_ack_n = 1'b0;
        bus.mem_rdata = 32'h1234_5678;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_mem_req",  bus.mem_req,  1'b1);
            check("rr_mem_addr", bus.mem_addr, (k % 2 == 0) ? 32'h20 : 32'h0800_0004);
            tick();
            check("rr_i_ack", bus.i_ack, (k % 2 == 0));
            check("rr_d_ack", bus.d_ack, (k % 2 == 1));
        end
        bus.i_req     = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_ack_n = 1'b1;
        tick();

        // Byte store with the ack delayed three cycles.
        bus.d_req   = 1'b1;
        bus.d_write = 1'b1;
        bus.d_size  = 2'b10;
        bus.d_addr  = 32'hF000_0000;
        bus.d_wdata = 32'h41;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("st_mem_req",   bus.mem_req,   1'b1);
            check("st_mem_write", bus.mem_write, 1'b1);
            check("st_mem_size",  bus.mem_size,  2'b10);
            check("st_mem_wdata", bus.mem_wdata, 32'h41);
            check("st_mem_addr",  bus.mem_addr,  32'hF000_0000);
            check("st_no_ack",    bus.d_ack,     1'b0);
        end
        bus.mem_ack_n = 1'b0;
        tick();
        check("st_d_ack",       bus.d_ack,   1'b1);
        check("st_mem_req_low", bus.mem_req, 1'b0);
        bus.d_req     = 1'b0;
        bus.mem_ack_n = 1'b1;
        tick();
        check("st_d_ack_once", bus.d_ack, 1'b0);

        // Reset in the middle of a data transaction.
        bus.d_req   = 1'b1;
        bus.d_write = 1'b0;
        bus.d_size  = 2'b00;
        bus.d_addr  = 32'h0000_0100;
        tick();
        check("mr_mem_req", bus.mem_req, 1'b1);
        rst = 1'b1;
        tick();
        check("mr_mem_req_0",   bus.mem_req,   1'b0);
        check("mr_mem_addr_0",  bus.mem_addr,  32'h0);
        check("mr_mem_write_0", bus.mem_write, 1'b0);
        check("mr_d_ack_0",     bus.d_ack,     1'b0);
        rst           = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_ack_n = 1'b0;
        tick();
        check("mr_late_ack_ignored", bus.d_ack,   1'b0);
        check("mr_still_idle",       bus.mem_req, 1'b0);
        bus.mem_ack_n = 1'b1;
        tick();
        check("mr_no_ack", bus.d_ack, 1'b0);

        // Randomized requesters and memory.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic [31:0] a;
            if (bus.i_ack || !bus.i_req) begin
                bus.i_req  = ($urandom_range(0, 9) < 6);
                bus.i_addr = $urandom() & 32'hFFFF_FFFC;
            end else if ($urandom_range(0, 49) == 0) begin
                bus.i_req = 1'b0;
            end
            if (bus.d_ack || !bus.d_req) begin
                a = $urandom();
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                bus.d_req   = ($urandom_range(0, 9) < 6);
                bus.d_write = $urandom_range(0, 1) == 1;
                bus.d_size  = 2'($urandom_range(0, 3));
                bus.d_addr  = a;
                bus.d_wdata = $urandom();
            end else if ($urandom_range(0, 49) == 0) begin
                bus.d_req = 1'b0;
            end
            bus.mem_ack_n = ($urandom_range(0, 4) >= 2);
            bus.mem_rdata = $urandom();
            rst           = ($urandom_range(0, 299) == 0);
            tick();
        end

        rst       = 1'b0;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
